// File: rtl/cache_pkg.sv
// Shared types and default sizes for the cache write buffer.
// The buffer's optional coalescing feature is selected with WBUF_COALESCE_EN (see cache_write_buffer.sv).
package cache_pkg;

    localparam int ADDR_W_DEF = 32;
    localparam int DATA_W_DEF = 32;
    localparam int DEPTH_DEF  = 4;

    // One buffered posted write at the default widths.
    typedef struct packed {
        logic                  valid;
        logic [ADDR_W_DEF-1:0] address;
        logic [DATA_W_DEF-1:0] data;
    } wbuf_entry_t;

    // Drain handshake towards RAM: idle, or holding a request for the head entry.
    typedef enum logic {
        IDLE = 1'b0,
        REQ  = 1'b1
    } drain_state_t;

endpackage

// File: rtl/cache_write_buffer_if.sv
// Bundle of the cache-side write/lookup signals and the RAM drain handshake.
// master = the surrounding cache/RAM environment, slave = the write buffer.
interface cache_write_buffer_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic              wr_valid;
    logic              wr_ready;
    logic [ADDR_W-1:0] wr_address;
    logic [DATA_W-1:0] wr_data;
    logic [ADDR_W-1:0] rd_address;
    logic              rd_hit;
    logic [DATA_W-1:0] rd_data;
    logic              ram_req;
    logic [ADDR_W-1:0] ram_address;
    logic [DATA_W-1:0] ram_data;
    logic              ram_ack;
    logic [CNT_W-1:0]  count;
    logic              empty;

    modport master (
        output wr_valid, wr_address, wr_data, rd_address, ram_ack,
        input  wr_ready, rd_hit, rd_data, ram_req, ram_address, ram_data, count, empty
    );

    modport slave (
        input  wr_valid, wr_address, wr_data, rd_address, ram_ack,
        output wr_ready, rd_hit, rd_data, ram_req, ram_address, ram_data, count, empty
    );

endinterface

// File: rtl/cache_wbuf_match.sv
// Parallel address compare over all buffer entries; returns the youngest valid match,
// i.e. the first hit walking backwards from the entry just before wr_ptr.
module cache_wbuf_match #(
    parameter  int ADDR_W = 32,
    parameter  int DEPTH  = 4,
    localparam int PTR_W  = $clog2(DEPTH)
) (
    input  logic [DEPTH-1:0]  valid_i,
    input  logic [ADDR_W-1:0] addr_i [DEPTH],
    input  logic [PTR_W-1:0]  wr_ptr_i,
    input  logic [ADDR_W-1:0] key_i,
    output logic              hit_o,
    output logic [PTR_W-1:0]  idx_o
);

    logic [PTR_W-1:0] cand;

    // Youngest-first priority search; pointer arithmetic wraps naturally at DEPTH.
    always_comb begin
        // NOTE: every output gets a default before the loop so no path leaves it unassigned (no latch).
        hit_o = 1'b0;
        idx_o = '0;
        cand  = '0;
        for (int k = 0; k < DEPTH; k++) begin
            cand = wr_ptr_i - PTR_W'(k + 1);
            if (!hit_o && valid_i[cand] && (addr_i[cand] == key_i)) begin
                hit_o = 1'b1;
                idx_o = cand;
            end
        end
    end

endmodule

// File: rtl/cache_write_buffer.sv
// Posted write buffer between the direct-mapped cache and backing RAM.
// Writes are queued in a circular FIFO and drained to RAM over a req/ack handshake;
// miss-path lookups are forwarded from pending entries.
// Define WBUF_COALESCE_EN to merge writes to an already-buffered address in place.
module cache_write_buffer
    import cache_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = DEPTH_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    cache_write_buffer_if.slave  bus
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [ADDR_W-1:0] addr_q [DEPTH];
    logic [DATA_W-1:0] data_q [DEPTH];
    logic [DEPTH-1:0]  valid_q;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    drain_state_t      state_q, state_d;

    logic              full;
    logic              accept, push, pop, coal_wr;
    logic              fwd_hit;
    logic [PTR_W-1:0]  fwd_idx;
    logic              coal_hit;
    logic [PTR_W-1:0]  coal_idx;

    assign full    = (count_q == CNT_W'(DEPTH));
    assign pop     = (state_q == REQ) && bus.ram_ack;
    assign accept  = bus.wr_valid && bus.wr_ready;
    assign coal_wr = accept && coal_hit;
    assign push    = accept && !coal_hit;

    // Full is judged on the registered count only; a same-cycle pop does not free a slot.
    assign bus.wr_ready = !full || coal_hit;

    // Forwarding lookup for the cache miss path; an incoming write is only visible after its edge.
    cache_wbuf_match #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) u_fwd_match (
        .valid_i  (valid_q),
        .addr_i   (addr_q),
        .wr_ptr_i (wr_ptr_q),
        .key_i    (bus.rd_address),
        .hit_o    (fwd_hit),
        .idx_o    (fwd_idx)
    );

    assign bus.rd_hit  = fwd_hit;
    assign bus.rd_data = fwd_hit ? data_q[fwd_idx] : '0;

`ifdef WBUF_COALESCE_EN
    logic [DEPTH-1:0] coal_valid;

    // The head under an outstanding request must stay stable, so it is excluded from merging.
    assign coal_valid = valid_q & ~((state_q == REQ) ? (DEPTH'(1) << rd_ptr_q) : '0);

    cache_wbuf_match #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) u_coal_match (
        .valid_i  (coal_valid),
        .addr_i   (addr_q),
        .wr_ptr_i (wr_ptr_q),
        .key_i    (bus.wr_address),
        .hit_o    (coal_hit),
        .idx_o    (coal_idx)
    );
`else
    assign coal_hit = 1'b0;
    assign coal_idx = '0;
`endif

    // Drain outputs come straight from the head entry while a request is outstanding.
    assign bus.ram_req     = (state_q == REQ);
    assign bus.ram_address = (state_q == REQ) ? addr_q[rd_ptr_q] : '0;
    assign bus.ram_data    = (state_q == REQ) ? data_q[rd_ptr_q] : '0;
    assign bus.count       = count_q;
    assign bus.empty       = (count_q == '0);

    // Next-state for pointers, occupancy and the drain FSM.
    always_comb begin
        wr_ptr_d = wr_ptr_q + PTR_W'(push);
        rd_ptr_d = rd_ptr_q + PTR_W'(pop);
        count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
        state_d  = state_q;
        case (state_q)
            IDLE:    if (count_q != '0) state_d = REQ;
            REQ:     if (bus.ram_ack) state_d = (count_q > CNT_W'(1)) ? REQ : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Control state: reset drops every pending write and withdraws any request at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            state_q  <= IDLE;
            valid_q  <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            state_q  <= state_d;
            if (pop)  valid_q[rd_ptr_q] <= 1'b0;
            if (push) valid_q[wr_ptr_q] <= 1'b1;
        end
    end

    // Entry payload storage: allocate at wr_ptr, or merge data into a matched entry.
    // NOTE: payload is not reset; valid_q gates every consumer, so stale contents are never observed.
    always_ff @(posedge clk) begin
        if (push) begin
            addr_q[wr_ptr_q] <= bus.wr_address;
            data_q[wr_ptr_q] <= bus.wr_data;
        end
        if (coal_wr) begin
            data_q[coal_idx] <= bus.wr_data;
        end
    end

endmodule

// File: tb/tb_cache_write_buffer.sv
// Self-checking bench for cache_write_buffer: directed scenarios plus randomized traffic,
// compared every cycle against a queue-based reference model of the buffer.
module tb_cache_write_buffer;

    localparam int DEPTH = 4;
`ifdef WBUF_COALESCE_EN
    localparam bit COAL = 1'b1;
`else
    localparam bit COAL = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    cache_write_buffer_if #(.ADDR_W(32), .DATA_W(32), .DEPTH(DEPTH)) bus ();

    cache_write_buffer #(.ADDR_W(32), .DATA_W(32), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [31:0] a;
        logic [31:0] d;
    } ent_t;

    ent_t q[$];        // pending writes, oldest at index 0
    bit   req_m;       // model: request outstanding towards RAM
    int   n_cmp = 0;
    int   n_bad = 0;

    logic [31:0] pool [6] = '{32'd0, 32'd1001425, 32'd2816867292, 32'd8, 32'd64, 32'd1001429};

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Index of the entry a write to address a would merge into, or -1.
    function automatic int coal_index(input logic [31:0] a);
        for (int j = q.size() - 1; j >= 0; j--)
            if (COAL && !(req_m && j == 0) && q[j].a == a) return j;
        return -1;
    endfunction

    task automatic compare_all();
        logic        hit;
        logic [31:0] rd;
        bit          rdy;
        hit = 1'b0;
        rd  = '0;
        for (int j = q.size() - 1; j >= 0; j--)
            if (!hit && q[j].a == bus.rd_address) begin
                hit = 1'b1;
                rd  = q[j].d;
            end
        rdy = (q.size() < DEPTH) || (coal_index(bus.wr_address) >= 0);
        check("count",    64'(bus.count),    64'(q.size()));
        check("empty",    64'(bus.empty),    64'(q.size() == 0));
        check("wr_ready", 64'(bus.wr_ready), 64'(rdy));
        check("rd_hit",   64'(bus.rd_hit),   64'(hit));
        check("rd_data",  64'(bus.rd_data),  64'(rd));
        check("ram_req",  64'(bus.ram_req),  64'(req_m));
        check("ram_addr", 64'(bus.ram_address), (req_m && q.size() > 0) ? 64'(q[0].a) : 64'd0);
        check("ram_data", 64'(bus.ram_data),    (req_m && q.size() > 0) ? 64'(q[0].d) : 64'd0);
    endtask

    // Apply one clock edge to the model using the inputs currently driven.
    task automatic model_step();
        int j;
        int old;
        bit pop;
        bit acc;
        j   = coal_index(bus.wr_address);
        old = q.size();
        pop = req_m && bus.ram_ack;
        acc = bus.wr_valid && (old < DEPTH || j >= 0);
        if (acc && j >= 0) q[j].d = bus.wr_data;
        if (pop) void'(q.pop_front());
        if (acc && j < 0) q.push_back('{bus.wr_address, bus.wr_data});
        if (!req_m) req_m = (old > 0);
        else if (bus.ram_ack) req_m = (old > 1);
    endtask

    task automatic cycle(input bit v, input logic [31:0] a, input logic [31:0] d,
                         input bit ack, input logic [31:0] ra);
        bus.wr_valid   = v;
        bus.wr_address = a;
        bus.wr_data    = d;
        bus.ram_ack    = ack;
        bus.rd_address = ra;
        @(negedge clk);
        compare_all();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic drain(input int n);
        for (int k = 0; k < n; k++) cycle(1'b0, '0, '0, 1'b1, '0);
    endtask

    initial begin
        rst_n          = 1'b0;
        bus.wr_valid   = 1'b0;
        bus.wr_address = '0;
        bus.wr_data    = '0;
        bus.ram_ack    = 1'b0;
        bus.rd_address = '0;
        q.delete();
        req_m = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Reset state with no activity.
        check("rst_empty",    64'(bus.empty),       64'd1);
        check("rst_wr_ready", 64'(bus.wr_ready),    64'd1);
        check("rst_ram_req",  64'(bus.ram_req),     64'd0);
        check("rst_rd_hit",   64'(bus.rd_hit),      64'd0);
        check("rst_count",    64'(bus.count),       64'd0);
        check("rst_ram_addr", 64'(bus.ram_address), 64'd0);

        // Single write held without ack: request appears after one cycle and stays stable.
        cycle(1'b1, 32'd2816867292, 32'd526421, 1'b0, '0);
        check("one_req_lat", 64'(bus.ram_req), 64'd0);
        for (int k = 0; k < 10; k++) cycle(1'b0, '0, '0, 1'b0, 32'd2816867292);
        check("one_ram_addr", 64'(bus.ram_address), 64'd2816867292);
        check("one_ram_data", 64'(bus.ram_data),    64'd526421);
        cycle(1'b0, '0, '0, 1'b1, '0);
        check("one_empty", 64'(bus.empty), 64'd1);

        // Fill to DEPTH, refuse a fifth push, drain in push order.
        cycle(1'b1, 32'd0,          32'd14528,    1'b0, '0);
        cycle(1'b1, 32'd1001425,    32'd25369366, 1'b0, '0);
        cycle(1'b1, 32'd2816867292, 32'd526421,   1'b0, '0);
        cycle(1'b1, 32'd8,          32'd7,        1'b0, '0);
        check("full_count",    64'(bus.count),    64'd4);
        check("full_wr_ready", 64'(bus.wr_ready), 64'd0);
        cycle(1'b1, 32'd99, 32'd99, 1'b0, 32'd99);
        check("full_5th_count", 64'(bus.count),  64'd4);
        check("full_5th_hit",   64'(bus.rd_hit), 64'd0);
        check("full_head_addr", 64'(bus.ram_address), 64'd0);
        drain(4);
        check("full_drained", 64'(bus.empty), 64'd1);

        // Duplicate addresses: youngest wins on lookup; merge only where enabled.
        cycle(1'b1, 32'd1001425, 32'd25369366, 1'b0, '0);
        cycle(1'b0, '0, '0, 1'b0, '0);
        cycle(1'b1, 32'd1001425, 32'd14528, 1'b0, '0);
        bus.rd_address = 32'd1001425;
        #1;
        check("fwd_hit",   64'(bus.rd_hit),  64'd1);
        check("fwd_data",  64'(bus.rd_data), 64'd14528);
        check("fwd_count", 64'(bus.count),   64'd2);
        cycle(1'b1, 32'd1001425, 32'd0, 1'b0, 32'd1001425);
        check("coal_count", 64'(bus.count), COAL ? 64'd2 : 64'd3);
        drain(5);

        // Full buffer with ack and push in the same cycle: push refused.
        cycle(1'b1, 32'd10, 32'd1, 1'b0, '0);
        cycle(1'b1, 32'd20, 32'd2, 1'b0, '0);
        cycle(1'b1, 32'd30, 32'd3, 1'b0, '0);
        cycle(1'b1, 32'd40, 32'd4, 1'b0, '0);
        cycle(1'b1, 32'd50, 32'd5, 1'b1, '0);
        check("ackpush_count", 64'(bus.count), 64'd3);
        cycle(1'b1, 32'd50, 32'd5, 1'b0, '0);
        check("ackpush_next", 64'(bus.count), 64'd4);
        drain(6);

        // Asynchronous reset in the middle of a request.
        cycle(1'b1, 32'd60, 32'd6, 1'b0, '0);
        cycle(1'b1, 32'd70, 32'd7, 1'b0, '0);
        cycle(1'b1, 32'd80, 32'd8, 1'b0, '0);
        bus.wr_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check("arst_ram_req", 64'(bus.ram_req), 64'd0);
        check("arst_count",   64'(bus.count),   64'd0);
        check("arst_empty",   64'(bus.empty),   64'd1);
        q.delete();
        req_m = 1'b0;
        #2;
        rst_n = 1'b1;
        cycle(1'b1, 32'd90, 32'd9, 1'b0, '0);
        cycle(1'b0, '0, '0, 1'b0, '0);
        check("arst_new_req",  64'(bus.ram_req),     64'd1);
        check("arst_new_addr", 64'(bus.ram_address), 64'd90);
        drain(2);

        // Randomized traffic against the model.
        for (int k = 0; k < 1500; k++) begin
            cycle(1'($urandom_range(0, 1)), pool[$urandom_range(0, 5)], $urandom,
                  $urandom_range(0, 2) == 0, pool[$urandom_range(0, 5)]);
        end
        drain(DEPTH + 2);
        check("final_empty", 64'(bus.empty), 64'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
